// File: rtl/tcgrom_arbiter.sv
// Round-robin arbiter sharing the tcgrom among glyph requesters, with optional burst lock.
// Define TCGROM_ARB_STATS_EN to add the max_wait starvation statistic output.
module tcgrom_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned MAX_BURST   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
`ifdef TCGROM_ARB_STATS_EN
  output logic [7:0]                max_wait,
`endif
  output logic                      busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [0:0] {StArb, StLocked} state_e;

  state_e              state_q;
  idx_t                ptr_q;
  idx_t                owner_q;
  logic [7:0]          burst_q;
  logic                rom_en_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic [DATA_W-1:0]   rd_data_q;
  // One-hot requester tag per stage; stage 0 lines up with rom_en.
  logic [NUM_REQ-1:0]  tag_q [ROM_LATENCY+1];

  logic                rr_found;
  idx_t                rr_idx;
  logic [IDX_W:0]      cand;
  logic                win_vld;
  idx_t                win_idx;
  logic [ADDR_W-1:0]   win_addr;
  logic [7:0]          burst_inc;

  function automatic idx_t inc_idx(input idx_t i);
    return (i == idx_t'(NUM_REQ - 1)) ? '0 : idx_t'(i + 1'b1);
  endfunction

  // Search starts at the pointer and wraps modulo NUM_REQ.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    cand     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!rr_found && req[cand[IDX_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_idx = rr_idx;
    win_vld = rr_found;
    if (state_q == StLocked) begin
      win_idx = owner_q;
      win_vld = req[owner_q];
    end
    win_vld = win_vld && !reset;
    gnt = '0;
    if (win_vld) begin
      gnt[win_idx] = 1'b1;
    end
  end

  assign win_addr  = req_addr[win_idx*ADDR_W +: ADDR_W];
  assign burst_inc = burst_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StArb;
      ptr_q      <= '0;
      owner_q    <= '0;
      burst_q    <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      rd_data_q  <= '0;
      for (int unsigned s = 0; s <= ROM_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      rom_en_q <= win_vld;
      if (win_vld) begin
        rom_addr_q <= win_addr;
      end
      tag_q[0] <= gnt;
      for (int unsigned s = 1; s <= ROM_LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
      // rom_data is valid in the cycle the tag reaches stage ROM_LATENCY-1.
      if (|tag_q[ROM_LATENCY-1]) begin
        rd_data_q <= rom_data;
      end
      unique case (state_q)
        StArb: begin
          if (win_vld) begin
            ptr_q <= inc_idx(win_idx);
            if (lock[win_idx]) begin
              state_q <= StLocked;
              owner_q <= win_idx;
              burst_q <= 8'd1;
            end
          end
        end
        StLocked: begin
          if (win_vld) begin
            burst_q <= burst_inc;
          end
          // A grant taken with lock low is the last one of the burst.
          if (!win_vld || !lock[owner_q] || burst_inc == 8'(MAX_BURST)) begin
            state_q <= StArb;
            ptr_q   <= inc_idx(owner_q);
            burst_q <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    busy = rom_en_q;
    for (int unsigned s = 0; s <= ROM_LATENCY; s++) begin
      busy = busy | (|tag_q[s]);
    end
  end

  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign rd_valid = tag_q[ROM_LATENCY];
  assign rd_data  = rd_data_q;

`ifdef TCGROM_ARB_STATS_EN
  logic [7:0] wait_q [NUM_REQ];
  logic [7:0] wait_d [NUM_REQ];
  logic [7:0] max_q;
  logic [7:0] max_d;

  always_comb begin
    max_d = max_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!req[i] || gnt[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] == 8'hff) begin
        wait_d[i] = 8'hff;
      end else begin
        wait_d[i] = wait_q[i] + 8'd1;
      end
      if (wait_d[i] > max_d) begin
        max_d = wait_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        wait_q[i] <= '0;
      end
      max_q <= '0;
    end else begin
      wait_q <= wait_d;
      max_q  <= max_d;
    end
  end

  assign max_wait = max_q;
`endif

endmodule

// File: tb/tb_tcgrom_arbiter.sv
// Scoreboard bench for tcgrom_arbiter: two instances (ROM_LATENCY 1 and 3) share all stimulus.
module tb_tcgrom_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [35:0] req_addr;
  logic [8:0]  addr_tab [4];

  logic [3:0]  gnt1, gnt3, rd_valid1, rd_valid3;
  logic        rom_en1, rom_en3, busy1, busy3;
  logic [8:0]  rom_addr1, rom_addr3;
  logic [7:0]  rom_data1, rom_data3, rd_data1, rd_data3;
`ifdef TCGROM_ARB_STATS_EN
  logic [7:0]  max_wait1, max_wait3;
`endif

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic [8:0] a3_q1, a3_q2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tcgrom_arbiter #(.ROM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .req_addr(req_addr),
    .gnt(gnt1), .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .rd_valid(rd_valid1), .rd_data(rd_data1),
`ifdef TCGROM_ARB_STATS_EN
    .max_wait(max_wait1),
`endif
    .busy(busy1)
  );

  tcgrom_arbiter #(.ROM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .req_addr(req_addr),
    .gnt(gnt3), .rom_en(rom_en3), .rom_addr(rom_addr3), .rom_data(rom_data3),
    .rd_valid(rd_valid3), .rd_data(rd_data3),
`ifdef TCGROM_ARB_STATS_EN
    .max_wait(max_wait3),
`endif
    .busy(busy3)
  );

  function automatic logic [7:0] rom_f(input logic [8:0] a);
    return a[7:0] ^ (a[8] ? 8'hA5 : 8'h5A);
  endfunction

  // ROM models: data is sampled at the edge ending the cycle ROM_LATENCY-1 after rom_en.
  assign rom_data1 = rom_f(rom_addr1);
  always @(posedge clk) begin
    a3_q1 <= rom_addr3;
    a3_q2 <= a3_q1;
  end
  assign rom_data3 = rom_f(a3_q2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_addrs(input logic [8:0] a0, input logic [8:0] a1,
                           input logic [8:0] a2, input logic [8:0] a3);
    addr_tab[0] = a0;
    addr_tab[1] = a1;
    addr_tab[2] = a2;
    addr_tab[3] = a3;
    req_addr = {a3, a2, a1, a0};
  endtask

  // Called just after a posedge; returns just after the next posedge.
  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [3:0] exp_gnt,
                      input string name);
    exp_t e;
    req  = r;
    lock = l;
    @(negedge clk);
    check({name, " gnt L1"}, 32'(gnt1), 32'(exp_gnt));
    check({name, " gnt L3"}, 32'(gnt3), 32'(exp_gnt));
    for (int i = 0; i < 4; i++) begin
      if (exp_gnt[i]) begin
        e.idx  = i;
        e.data = rom_f(addr_tab[i]);
        e.due  = cyc + 2;
        q1.push_back(e);
        e.due  = cyc + 4;
        q3.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    lock  = '0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q1.delete();
    q3.delete();
    @(negedge clk);
    check("post-reset busy L1", 32'(busy1), 32'd0);
    check("post-reset busy L3", 32'(busy3), 32'd0);
    check("post-reset rom_en L3", 32'(rom_en3), 32'd0);
    check("post-reset rd_data L1", 32'(rd_data1), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic mon(input int lat, input logic [3:0] v, input logic [7:0] d);
    exp_t e;
    if (v === 4'b0000) return;
    check($sformatf("rd_valid one-hot L%0d", lat), 32'($onehot(v)), 32'd1);
    if ((lat == 1 && q1.size() == 0) || (lat == 3 && q3.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected rd_valid L%0d: got %b expected none (cycle %0d)", lat, v, cyc);
      return;
    end
    e = (lat == 1) ? q1.pop_front() : q3.pop_front();
    check($sformatf("rd_valid L%0d", lat), 32'(v), 32'(1) << e.idx);
    check($sformatf("rd_data L%0d", lat), 32'(d), 32'(e.data));
    check($sformatf("rd latency L%0d", lat), 32'(cyc), 32'(e.due));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(1, rd_valid1, rd_data1);
      mon(3, rd_valid3, rd_data3);
    end
  end

  initial begin
    reset = 1'b1;
    req   = 4'b1111;
    lock  = '0;
    set_addrs(9'h000, 9'h000, 9'h000, 9'h000);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset gnt L1", 32'(gnt1), 32'd0);
    check("reset rom_en L1", 32'(rom_en1), 32'd0);
    check("reset rom_addr L1", 32'(rom_addr1), 32'd0);
    check("reset rd_valid L3", 32'(rd_valid3), 32'd0);
    check("reset busy L1", 32'(busy1), 32'd0);
    check("reset rd_data L3", 32'(rd_data3), 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    req    = '0;
    mon_en = 1'b1;

    // Single requester 2: gnt cycle 0, rom_en cycle 1, rd_valid cycle 2.
    set_addrs(9'h011, 9'h022, 9'h100, 9'h1FF);
    step(4'b0100, 4'b0000, 4'b0100, "single");
    req = '0;
    @(negedge clk);
    check("single rom_en L1", 32'(rom_en1), 32'd1);
    check("single rom_addr L1", 32'(rom_addr1), 32'h100);
    check("single busy L1", 32'(busy1), 32'd1);
    @(posedge clk);
    #1;
    repeat (4) step(4'b0000, 4'b0000, 4'b0000, "idle");

    // Two reads in flight, then reset: the tail must never return.
    step(4'b0010, 4'b0000, 4'b0010, "inflight a");
    step(4'b0100, 4'b0000, 4'b0100, "inflight b");
    do_reset();

    // All four requesting from pointer 0.
    set_addrs(9'h0A0, 9'h0B1, 9'h1C2, 9'h0D3);
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 4'b0000, 4'(1 << (k % 4)), "rr all");
    end

    // Requester 1 locked against requester 3: capped at 16 grants.
    set_addrs(9'h003, 9'h1E4, 9'h005, 9'h0F6);
    for (int k = 0; k < 16; k++) begin
      step(4'b1010, 4'b0010, 4'b0010, "burst owner");
    end
    step(4'b1010, 4'b0010, 4'b1000, "burst cap other");
    step(4'b1010, 4'b0010, 4'b0010, "burst owner again");
    step(4'b0000, 4'b0000, 4'b0000, "burst req drop");

    // Alternating 0/1 from pointer 2, wrapping 3 -> 0.
    set_addrs(9'h1AB, 9'h0CD, 9'h000, 9'h000);
    for (int k = 0; k < 4; k++) begin
      step((k % 2 == 0) ? 4'b0001 : 4'b0010, 4'b0000,
           (k % 2 == 0) ? 4'b0001 : 4'b0010, "alt 0/1");
    end
    repeat (6) step(4'b0000, 4'b0000, 4'b0000, "drain");

    // Requester 0 locked for 10 grants while requester 2 waits.
    do_reset();
    set_addrs(9'h150, 9'h000, 9'h0E7, 9'h000);
    for (int k = 0; k < 9; k++) begin
      step(4'b0101, 4'b0001, 4'b0001, "stats lock");
    end
    step(4'b0101, 4'b0000, 4'b0001, "stats last");
    step(4'b0101, 4'b0000, 4'b0100, "stats waiter");
    step(4'b0001, 4'b0000, 4'b0001, "stats wrap");
    repeat (6) step(4'b0000, 4'b0000, 4'b0000, "drain");
`ifdef TCGROM_ARB_STATS_EN
    check("max_wait L1", 32'(max_wait1), 32'd10);
    check("max_wait L3", 32'(max_wait3), 32'd10);
`endif

    check("queue empty L1", 32'(q1.size()), 32'd0);
    check("queue empty L3", 32'(q3.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
